ilk_rx_disparity: RTL and testbench

Receive-side 64b/67b word checker for an Interlaken lane. It accepts raw 67-bit lane words after block alignment. For each word it:
- removes the transmitter's payload inversion,
- classifies the sync header,
- tracks signed running disparity against the Interlaken bound, and
- keeps a saturating error counter.

It sits between the RX block aligner and the RX descrambler/framing layer. It is the counterpart of the TX disparity encoder, which builds its word ones-counts from three-operand adders.

---
 rtl/ilk_rx_disparity_if.sv | 29 ++
 rtl/ilk_rx_disparity.sv | 165 ++++++++++++++++
 tb/tb_ilk_rx_disparity.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ilk_rx_disparity_if.sv
// Lane-word bus for the Interlaken RX disparity checker.
// Upstream side (block aligner) drives din/din_valid; the checker returns the
// de-inverted payload with its classification flags.
//   din        [66] inversion flag, [65:64] sync header, [63:0] payload
//   din_valid  din is taken on this clock edge (no backpressure)
//   dout       de-inverted payload
//   dout_ctrl  control word (header 2'b10)
//   dout_valid qualifies dout, dout_ctrl, hdr_err, disp_err
//   hdr_err    illegal sync header (2'b00 / 2'b11)
//   disp_err   running-disparity bound exceeded on this word
interface ilk_rx_disparity_if;
  logic [66:0] din;
  logic        din_valid;
  logic [63:0] dout;
  logic        dout_ctrl;
  logic        dout_valid;
  logic        hdr_err;
  logic        disp_err;

  modport master (
    output din, din_valid,
    input  dout, dout_ctrl, dout_valid, hdr_err, disp_err
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_ctrl, dout_valid, hdr_err, disp_err
  );
endinterface

// File: rtl/ilk_rx_disparity.sv
// Interlaken RX 64b/67b word checker: undoes payload inversion, classifies the
// sync header, tracks signed running disparity against RD_LIMIT and keeps a
// saturating count of flagged words. Three pipeline stages, one word/clock.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   clr_cnt  synchronous clear of err_cnt (wins over an increment)
//   bus      lane-word interface (slave side)
//   rd_out   running disparity, two's complement
//   err_cnt  saturating count of words with hdr_err or disp_err
module ilk_rx_disparity #(
  parameter int RD_LIMIT  = 96,
  parameter int RD_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_cnt,
  ilk_rx_disparity_if.slave    bus,
  output logic [RD_WIDTH-1:0]  rd_out,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic signed [RD_WIDTH-1:0] LIM_POS = RD_WIDTH'(RD_LIMIT);
  localparam logic signed [RD_WIDTH-1:0] LIM_NEG = RD_WIDTH'(-RD_LIMIT);

  // S1
  logic        s1_valid_d, s1_valid_q;
  logic [63:0] s1_payload_d, s1_payload_q;
  logic        s1_ctrl_d, s1_ctrl_q;
  logic        s1_hdr_err_d, s1_hdr_err_q;
  logic [4:0]  s1_psum_d [8];
  logic [4:0]  s1_psum_q [8];

  // S2
  logic                       s2_valid_d, s2_valid_q;
  logic [63:0]                s2_payload_d, s2_payload_q;
  logic                       s2_ctrl_d, s2_ctrl_q;
  logic                       s2_hdr_err_d, s2_hdr_err_q;
  logic signed [RD_WIDTH-1:0] s2_d_d, s2_d_q;

  // S3 / outputs
  logic                       dout_valid_d, dout_valid_q;
  logic [63:0]                dout_d, dout_q;
  logic                       dout_ctrl_d, dout_ctrl_q;
  logic                       hdr_err_d, hdr_err_q;
  logic                       disp_err_d, disp_err_q;
  logic signed [RD_WIDTH-1:0] rd_d, rd_q;
  logic [CNT_WIDTH-1:0]       err_cnt_d, err_cnt_q;

  // Popcount tree intermediates
  logic [68:0]                din_pad;
  logic [2:0]                 lvl1 [24];
  logic [4:0]                 psum_pad [9];
  logic [6:0]                 lvl3 [3];
  logic [8:0]                 popcnt;
  logic signed [RD_WIDTH-1:0] rd_next;
  logic                       viol;

  always_comb begin
    // S1: de-invert, decode header, first two levels of the popcount tree.
    // Disparity is measured on the line bits, so the flag bit is counted too.
    din_pad      = {2'b00, bus.din};
    s1_valid_d   = bus.din_valid;
    s1_payload_d = bus.din[66] ? ~bus.din[63:0] : bus.din[63:0];
    s1_ctrl_d    = (bus.din[65:64] == 2'b10);
    s1_hdr_err_d = (bus.din[65:64] == 2'b00) || (bus.din[65:64] == 2'b11);
    for (int i = 0; i < 23; i++) begin
      lvl1[i] = 3'(din_pad[3*i]) + 3'(din_pad[3*i+1]) + 3'(din_pad[3*i+2]);
    end
    lvl1[23] = 3'd0;
    for (int j = 0; j < 8; j++) begin
      s1_psum_d[j] = 5'(lvl1[3*j]) + 5'(lvl1[3*j+1]) + 5'(lvl1[3*j+2]);
    end

    // S2: finish the tree, then d = 2p - 67.
    for (int j = 0; j < 8; j++) begin
      psum_pad[j] = s1_psum_q[j];
    end
    psum_pad[8] = 5'd0;
    for (int k = 0; k < 3; k++) begin
      lvl3[k] = 7'(psum_pad[3*k]) + 7'(psum_pad[3*k+1]) + 7'(psum_pad[3*k+2]);
    end
    popcnt       = 9'(lvl3[0]) + 9'(lvl3[1]) + 9'(lvl3[2]);
    s2_valid_d   = s1_valid_q;
    s2_payload_d = s1_payload_q;
    s2_ctrl_d    = s1_ctrl_q;
    s2_hdr_err_d = s1_hdr_err_q;
    s2_d_d       = RD_WIDTH'({popcnt, 1'b0}) - RD_WIDTH'(67);

    // S3: running disparity uses its own registered rd, so back-to-back
    // words chain without a hazard. A violation resyncs rd to 0.
    rd_next      = rd_q + s2_d_q;
    viol         = (rd_next > LIM_POS) || (rd_next < LIM_NEG);
    dout_valid_d = s2_valid_q;
    dout_d       = dout_q;
    dout_ctrl_d  = dout_ctrl_q;
    hdr_err_d    = 1'b0;
    disp_err_d   = 1'b0;
    rd_d         = rd_q;
    err_cnt_d    = err_cnt_q;
    if (s2_valid_q) begin
      dout_d      = s2_payload_q;
      dout_ctrl_d = s2_ctrl_q;
      hdr_err_d   = s2_hdr_err_q;
      disp_err_d  = viol;
      rd_d        = viol ? '0 : rd_next;
      if ((s2_hdr_err_q || viol) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_payload_q <= '0;
      s1_ctrl_q    <= 1'b0;
      s1_hdr_err_q <= 1'b0;
      for (int j = 0; j < 8; j++) s1_psum_q[j] <= '0;
      s2_valid_q   <= 1'b0;
      s2_payload_q <= '0;
      s2_ctrl_q    <= 1'b0;
      s2_hdr_err_q <= 1'b0;
      s2_d_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_ctrl_q  <= 1'b0;
      hdr_err_q    <= 1'b0;
      disp_err_q   <= 1'b0;
      rd_q         <= '0;
      err_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_payload_q <= s1_payload_d;
      s1_ctrl_q    <= s1_ctrl_d;
      s1_hdr_err_q <= s1_hdr_err_d;
      for (int j = 0; j < 8; j++) s1_psum_q[j] <= s1_psum_d[j];
      s2_valid_q   <= s2_valid_d;
      s2_payload_q <= s2_payload_d;
      s2_ctrl_q    <= s2_ctrl_d;
      s2_hdr_err_q <= s2_hdr_err_d;
      s2_d_q       <= s2_d_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_ctrl_q  <= dout_ctrl_d;
      hdr_err_q    <= hdr_err_d;
      disp_err_q   <= disp_err_d;
      rd_q         <= rd_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_ctrl  = dout_ctrl_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.hdr_err    = hdr_err_q;
  assign bus.disp_err   = disp_err_q;
  assign rd_out         = rd_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_ilk_rx_disparity.sv
// Directed self-checking bench for ilk_rx_disparity (CNT_WIDTH=4 so the
// saturation case is reachable quickly).
module tb_ilk_rx_disparity;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [9:0] rd_out;
  logic [3:0] err_cnt;
  int total = 0;
  int bad = 0;

  ilk_rx_disparity_if bus ();

  ilk_rx_disparity #(.RD_LIMIT(96), .RD_WIDTH(10), .CNT_WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_cnt (clr_cnt),
    .bus     (bus.slave),
    .rd_out  (rd_out),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [66:0] W_PLAIN = {1'b0, 2'b01, 64'h0123456789ABCDEF};
  localparam logic [66:0] W_INVC  = {1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [66:0] W_H00   = {1'b0, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [66:0] W_H11   = {1'b0, 2'b11, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [66:0] W_ZERO  = {1'b0, 2'b01, 64'h0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.din_valid = 1'b0;
    clr_cnt = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Word captured on the first tick; visible after the third.
  task automatic send_word(input logic [66:0] w);
    bus.din = w;
    bus.din_valid = 1'b1;
    tick;
    bus.din_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    bus.din = W_INVC;
    bus.din_valid = 1'b1;
    rst_n = 1'b0;
    tick; tick; tick;
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.dout_valid); end
    total++; if (bus.dout !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", bus.dout); end
    total++; if (rd_out !== 10'h0) begin bad++; $display("FAIL reset_rd got=%h want=0", rd_out); end
    total++; if (err_cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", err_cnt); end
    total++; if (bus.hdr_err !== 1'b0 || bus.disp_err !== 1'b0 || bus.dout_ctrl !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", bus.hdr_err, bus.disp_err, bus.dout_ctrl);
    end
    bus.din_valid = 1'b0;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_plain;
    do_reset;
    send_word(W_PLAIN);
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%b want=1", bus.dout_valid); end
    total++; if (bus.dout !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL plain_dout got=%h want=0123456789abcdef", bus.dout); end
    total++; if (bus.dout_ctrl !== 1'b0 || bus.hdr_err !== 1'b0 || bus.disp_err !== 1'b0) begin
      bad++; $display("FAIL plain_flags got=%b%b%b want=000", bus.dout_ctrl, bus.hdr_err, bus.disp_err);
    end
    total++; if (rd_out !== 10'h3FF) begin bad++; $display("FAIL plain_rd got=%h want=3ff", rd_out); end
    tick;
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL plain_bubble got=%b want=0", bus.dout_valid); end
  endtask

  task automatic test_inv_ctrl;
    do_reset;
    send_word(W_INVC);
    total++; if (bus.dout !== 64'h0) begin bad++; $display("FAIL invc_dout got=%h want=0", bus.dout); end
    total++; if (bus.dout_ctrl !== 1'b1) begin bad++; $display("FAIL invc_ctrl got=%b want=1", bus.dout_ctrl); end
    total++; if (rd_out !== 10'h041) begin bad++; $display("FAIL invc_rd got=%h want=041", rd_out); end
  endtask

  task automatic test_disparity;
    do_reset;
    bus.din = W_INVC;
    bus.din_valid = 1'b1;
    tick;
    tick;
    bus.din_valid = 1'b0;
    tick;
    total++; if (bus.disp_err !== 1'b0 || rd_out !== 10'h041) begin
      bad++; $display("FAIL disp_first got=%b/%h want=0/041", bus.disp_err, rd_out);
    end
    tick;
    total++; if (bus.disp_err !== 1'b1) begin bad++; $display("FAIL disp_second_err got=%b want=1", bus.disp_err); end
    total++; if (rd_out !== 10'h0) begin bad++; $display("FAIL disp_second_rd got=%h want=0", rd_out); end
    total++; if (err_cnt !== 4'h1) begin bad++; $display("FAIL disp_second_cnt got=%h want=1", err_cnt); end
    tick;
    total++; if (bus.disp_err !== 1'b0 || bus.dout_valid !== 1'b0 || err_cnt !== 4'h1) begin
      bad++; $display("FAIL disp_hold got=%b/%b/%h want=0/0/1", bus.disp_err, bus.dout_valid, err_cnt);
    end
  endtask

  task automatic test_hdr_err;
    do_reset;
    bus.din = W_H00;
    bus.din_valid = 1'b1;
    tick;
    bus.din = W_H11;
    tick;
    bus.din_valid = 1'b0;
    tick;
    total++; if (bus.hdr_err !== 1'b1 || bus.dout_ctrl !== 1'b0) begin
      bad++; $display("FAIL hdr00_flags got=%b/%b want=1/0", bus.hdr_err, bus.dout_ctrl);
    end
    total++; if (bus.dout !== 64'hAAAA_AAAA_AAAA_AAAA) begin bad++; $display("FAIL hdr00_dout got=%h want=aaaaaaaaaaaaaaaa", bus.dout); end
    total++; if (err_cnt !== 4'h1 || rd_out !== 10'h3FD) begin
      bad++; $display("FAIL hdr00_cnt_rd got=%h/%h want=1/3fd", err_cnt, rd_out);
    end
    tick;
    total++; if (bus.hdr_err !== 1'b1 || bus.dout_ctrl !== 1'b0) begin
      bad++; $display("FAIL hdr11_flags got=%b/%b want=1/0", bus.hdr_err, bus.dout_ctrl);
    end
    total++; if (err_cnt !== 4'h2 || rd_out !== 10'h3FE) begin
      bad++; $display("FAIL hdr11_cnt_rd got=%h/%h want=2/3fe", err_cnt, rd_out);
    end
  endtask

  task automatic test_saturation;
    do_reset;
    bus.din = W_H11;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    bus.din_valid = 1'b0;
    tick;
    tick;
    total++; if (err_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%h want=f", err_cnt); end
    tick;
    total++; if (err_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold got=%h want=f", err_cnt); end
    // clr_cnt on the edge where a flagged word is registered into S3
    for (int r = 0; r < 2; r++) begin
      bus.din = W_H11;
      bus.din_valid = 1'b1;
      tick;
      bus.din_valid = 1'b0;
      tick;
      clr_cnt = 1'b1;
      tick;
      clr_cnt = 1'b0;
      total++; if (err_cnt !== 4'h0) begin bad++; $display("FAIL clr_cnt_%0d got=%h want=0", r, err_cnt); end
    end
  endtask

  task automatic test_valid_pattern;
    logic exp_v;
    do_reset;
    bus.din = W_PLAIN;
    for (int c = 0; c < 8; c++) begin
      bus.din_valid = (c == 0) || (c == 2) || (c == 3);
      exp_v = (c == 3) || (c == 5) || (c == 6);
      total++; if (bus.dout_valid !== exp_v) begin
        bad++; $display("FAIL pattern_c%0d got=%b want=%b", c, bus.dout_valid, exp_v);
      end
      tick;
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic test_reset_midstream;
    do_reset;
    bus.din = W_PLAIN;
    for (int c = 0; c < 4; c++) begin
      bus.din_valid = (c == 0) || (c == 2) || (c == 3);
      tick;
    end
    bus.din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (bus.dout_valid !== 1'b0 || bus.dout !== 64'h0 || bus.dout_ctrl !== 1'b0) begin
      bad++; $display("FAIL mid_rst_out got=%b/%h/%b want=0/0/0", bus.dout_valid, bus.dout, bus.dout_ctrl);
    end
    total++; if (rd_out !== 10'h0 || err_cnt !== 4'h0 || bus.hdr_err !== 1'b0 || bus.disp_err !== 1'b0) begin
      bad++; $display("FAIL mid_rst_state got=%h/%h/%b/%b want=0/0/0/0", rd_out, err_cnt, bus.hdr_err, bus.disp_err);
    end
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL mid_discard_%0d got=%b want=0", c, bus.dout_valid); end
    end
    send_word(W_ZERO);
    total++; if (bus.dout_valid !== 1'b1 || rd_out !== 10'h3BF) begin
      bad++; $display("FAIL mid_new_word got=%b/%h want=1/3bf", bus.dout_valid, rd_out);
    end
  endtask

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    test_reset;
    test_plain;
    test_inv_ctrl;
    test_disparity;
    test_hdr_err;
    test_saturation;
    test_valid_pattern;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
